// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
// Control unit for the 5-stage 16-bit pipelined CPU. Decodes the instruction
// in decode into datapath controls (Mealy, same-cycle) and sequences
// run/flush/stall/drain/halt, load-use hazard bubbles and an issue counter.
module pipeline_control_unit #(
   parameter int LOAD_STALL   = 2,   // bubbles on a load-use hazard (1..3)
   parameter int DRAIN_CYCLES = 3    // cycles to drain E/M/W after HALT
) (
   input  logic        clk,
   input  logic        reset,        // asynchronous, active-low
   input  logic        start,
   input  logic [3:0]  opcodeDP,
   input  logic [3:0]  destAddD,
   input  logic [3:0]  srcAdd1D,
   input  logic [3:0]  srcAdd2D,
   output logic        enable,
   output logic        branchC,
   output logic        flushC,
   output logic        RegWriteC,
   output logic        MemWriteC,
   output logic        MemToRegC,
   output logic        immediateC,
   output logic        forwardC,
   output logic [1:0]  alufuncC,
   output logic        halted,
   output logic [15:0] issueCount
);

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_FLUSH, S_STALL, S_DRAIN, S_HALTED
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'b0110;
   localparam logic [3:0] OP_JMP   = 4'b1000;
   localparam logic [3:0] OP_HALT  = 4'b1111;
   localparam logic [7:0] C_STALL  = 8'(LOAD_STALL);
   localparam logic [7:0] C_DRAIN  = 8'(DRAIN_CYCLES);

   state_t      r_state, w_state_next;
   logic [7:0]  r_cnt, w_cnt_next;
   logic        r_ll_valid, w_ll_valid_next;
   logic [3:0]  r_ll_dest, w_ll_dest_next;
   logic [15:0] r_issue, w_issue_next;

   logic        w_reads1, w_reads2, w_hazard;

   // The detecting cycle is itself the first bubble, so the STALL/DRAIN
   // states last one cycle less than the loaded count: leave when the
   // counter is about to reach 1.
   assign w_reads1 = (opcodeDP >= 4'd1) && (opcodeDP <= 4'd7);
   assign w_reads2 = ((opcodeDP >= 4'd1) && (opcodeDP <= 4'd4)) || (opcodeDP == 4'd7);
   assign w_hazard = r_ll_valid &&
                     ((w_reads1 && (srcAdd1D == r_ll_dest)) ||
                      (w_reads2 && (srcAdd2D == r_ll_dest)));

   assign issueCount = r_issue;

   // Next-state, counters and Mealy control outputs
   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_ll_valid_next = 1'b0;
      w_ll_dest_next  = r_ll_dest;
      w_issue_next    = r_issue;
      enable          = 1'b0;
      branchC         = 1'b0;
      flushC          = 1'b0;
      RegWriteC       = 1'b0;
      MemWriteC       = 1'b0;
      MemToRegC       = 1'b0;
      immediateC      = 1'b0;
      forwardC        = 1'b0;
      alufuncC        = 2'b00;
      halted          = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (w_hazard) begin
               flushC       = 1'b1;
               w_cnt_next   = C_STALL;
               w_state_next = (LOAD_STALL <= 1) ? S_RUN : S_STALL;
            end else if (opcodeDP == OP_HALT) begin
               flushC       = 1'b1;
               w_cnt_next   = C_DRAIN;
               w_state_next = (DRAIN_CYCLES <= 1) ? S_HALTED : S_DRAIN;
            end else begin
               enable = 1'b1;
               case (opcodeDP)
                  4'b0001: begin RegWriteC = 1'b1; forwardC = 1'b1; alufuncC = 2'b00; end
                  4'b0010: begin RegWriteC = 1'b1; forwardC = 1'b1; alufuncC = 2'b01; end
                  4'b0011: begin RegWriteC = 1'b1; forwardC = 1'b1; alufuncC = 2'b10; end
                  4'b0100: begin RegWriteC = 1'b1; forwardC = 1'b1; alufuncC = 2'b11; end
                  4'b0101: begin RegWriteC = 1'b1; forwardC = 1'b1; immediateC = 1'b1; end
                  4'b0110: begin RegWriteC = 1'b1; MemToRegC = 1'b1; immediateC = 1'b1; end
                  4'b0111: begin MemWriteC = 1'b1; immediateC = 1'b1; end
                  4'b1000: begin branchC = 1'b1; w_state_next = S_FLUSH; end
                  default: ;
               endcase
               if ((opcodeDP >= 4'd1) && (opcodeDP <= 4'd8))
                  w_issue_next = 16'(r_issue + 16'd1);
               if (opcodeDP == OP_LOAD) begin
                  w_ll_valid_next = 1'b1;
                  w_ll_dest_next  = destAddD;
               end
            end
         end
         S_FLUSH: begin
            enable       = 1'b1;
            flushC       = 1'b1;
            w_state_next = S_RUN;
         end
         S_STALL: begin
            flushC     = 1'b1;
            w_cnt_next = r_cnt - 8'd1;
            if (r_cnt <= 8'd2) w_state_next = S_RUN;
         end
         S_DRAIN: begin
            flushC     = 1'b1;
            w_cnt_next = r_cnt - 8'd1;
            if (r_cnt <= 8'd2) w_state_next = S_HALTED;
         end
         S_HALTED: begin
            halted = 1'b1;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State, counters, last-load tracking and issue count registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_ll_valid <= 1'b0;
         r_ll_dest  <= 4'd0;
         r_issue    <= 16'd0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_ll_valid <= w_ll_valid_next;
         r_ll_dest  <= w_ll_dest_next;
         r_issue    <= w_issue_next;
      end
   end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Testbench for pipeline_control_unit: directed vector table, hand-written
// reset/wrap sequences and a randomized run against a queue-based model.
module tb_pipeline_control_unit;

   localparam int LOAD_STALL   = 2;
   localparam int DRAIN_CYCLES = 3;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [3:0]  opcodeDP, destAddD, srcAdd1D, srcAdd2D;
   logic        enable, branchC, flushC, RegWriteC, MemWriteC, MemToRegC;
   logic        immediateC, forwardC, halted;
   logic [1:0]  alufuncC;
   logic [15:0] issueCount;
   logic [10:0] act;

   always #5 clk = ~clk;

   pipeline_control_unit #(.LOAD_STALL(LOAD_STALL), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
      .clk(clk), .reset(reset), .start(start),
      .opcodeDP(opcodeDP), .destAddD(destAddD), .srcAdd1D(srcAdd1D), .srcAdd2D(srcAdd2D),
      .enable(enable), .branchC(branchC), .flushC(flushC),
      .RegWriteC(RegWriteC), .MemWriteC(MemWriteC), .MemToRegC(MemToRegC),
      .immediateC(immediateC), .forwardC(forwardC), .alufuncC(alufuncC),
      .halted(halted), .issueCount(issueCount)
   );

   assign act = {enable, branchC, flushC, RegWriteC, MemWriteC, MemToRegC,
                 immediateC, forwardC, alufuncC, halted};

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [10:0] mk(bit en, bit br, bit fl, bit rw, bit mw, bit mtr,
                                      bit imm, bit fwd, bit [1:0] alu, bit h);
      return {en, br, fl, rw, mw, mtr, imm, fwd, alu, h};
   endfunction

   logic [10:0] E_IDLE, E_BUB, E_SQ, E_ADDI, E_LOAD, E_STORE, E_JMP, E_NOP, E_HALTED;
   function automatic logic [10:0] e_alu(bit [1:0] a);
      return mk(1, 0, 0, 1, 0, 0, 0, 1, a, 0);
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 30) $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input bit st, input logic [3:0] op, input logic [3:0] d,
                        input logic [3:0] s1, input logic [3:0] s2);
      @(negedge clk);
      start = st; opcodeDP = op; destAddD = d; srcAdd1D = s1; srcAdd2D = s2;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; start = 1'b0; opcodeDP = 4'd0; destAddD = 4'd0;
      srcAdd1D = 4'd0; srcAdd2D = 4'd0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // ---------------- reference model ----------------
   // Forced non-decode cycles are held in a queue: 1 = squash slot after a
   // jump (enable stays high), 2 = held bubble (enable low).
   bit          m_run, m_halted, m_halt_pending, m_llv;
   logic [3:0]  m_lld;
   logic [15:0] m_cnt;
   int          m_q[$];

   task automatic model_reset();
      m_run = 0; m_halted = 0; m_halt_pending = 0; m_llv = 0; m_lld = 0; m_cnt = 0;
      m_q.delete();
   endtask

   function automatic logic [10:0] spec_decode(logic [3:0] op);
      case (op)
         4'd1: return e_alu(2'b00);
         4'd2: return e_alu(2'b01);
         4'd3: return e_alu(2'b10);
         4'd4: return e_alu(2'b11);
         4'd5: return E_ADDI;
         4'd6: return E_LOAD;
         4'd7: return E_STORE;
         4'd8: return E_JMP;
         default: return E_NOP;
      endcase
   endfunction

   task automatic model_step(input bit st, input logic [3:0] op, input logic [3:0] d,
                             input logic [3:0] s1, input logic [3:0] s2,
                             output logic [10:0] exp);
      bit hz;
      int k;
      exp = E_IDLE;
      if (m_halted) begin
         exp = E_HALTED;
      end else if (!m_run) begin
         if (st) m_run = 1;
      end else if (m_q.size() > 0) begin
         k = m_q.pop_front();
         exp = (k == 1) ? E_SQ : E_BUB;
         m_llv = 0;
         if (m_halt_pending && m_q.size() == 0) m_halted = 1;
      end else begin
         hz = m_llv && (((op >= 1 && op <= 7) && s1 == m_lld) ||
                        (((op >= 1 && op <= 4) || op == 7) && s2 == m_lld));
         if (hz) begin
            exp = E_BUB;
            for (int i = 0; i < LOAD_STALL - 1; i++) m_q.push_back(2);
            m_llv = 0;
         end else if (op == 4'd15) begin
            exp = E_BUB;
            for (int i = 0; i < DRAIN_CYCLES - 1; i++) m_q.push_back(2);
            m_halt_pending = 1;
            if (m_q.size() == 0) m_halted = 1;
            m_llv = 0;
         end else begin
            exp = spec_decode(op);
            if (op == 4'd8) m_q.push_back(1);
            if (op >= 1 && op <= 8) m_cnt = m_cnt + 16'd1;
            m_llv = (op == 4'd6);
            m_lld = d;
         end
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit          st;
      logic [3:0]  op, d, s1, s2;
      logic [10:0] exp;
      logic [15:0] cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic addv(input bit st, input logic [3:0] op, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic [10:0] exp, input logic [15:0] cnt);
      vec_t v;
      v.st = st; v.op = op; v.d = d; v.s1 = s1; v.s2 = s2; v.exp = exp; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   initial begin
      logic [10:0] exp;
      E_IDLE   = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      E_BUB    = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
      E_SQ     = mk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
      E_ADDI   = mk(1, 0, 0, 1, 0, 0, 1, 1, 2'b00, 0);
      E_LOAD   = mk(1, 0, 0, 1, 0, 1, 1, 0, 2'b00, 0);
      E_STORE  = mk(1, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0);
      E_JMP    = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      E_NOP    = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      E_HALTED = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);

      //   st op  d  s1 s2  expected        count
      addv(1, 0,  0, 0, 0,  E_IDLE,         16'd0);   // IDLE, start
      addv(0, 1,  0, 0, 0,  e_alu(2'b00),   16'd0);   // ADD
      addv(0, 2,  0, 0, 0,  e_alu(2'b01),   16'd1);   // SUB
      addv(0, 3,  0, 0, 0,  e_alu(2'b10),   16'd2);   // AND
      addv(0, 4,  0, 0, 0,  e_alu(2'b11),   16'd3);   // OR
      addv(0, 5,  0, 0, 0,  E_ADDI,         16'd4);   // ADDI
      addv(0, 6,  3, 0, 0,  E_LOAD,         16'd5);   // LOAD r3
      addv(0, 1,  0, 3, 0,  E_BUB,          16'd6);   // ADD uses r3: hazard
      addv(0, 1,  0, 3, 0,  E_BUB,          16'd6);   // stall
      addv(0, 1,  0, 3, 0,  e_alu(2'b00),   16'd6);   // ADD issues
      addv(0, 7,  0, 1, 2,  E_STORE,        16'd7);   // STORE
      addv(0, 8,  0, 0, 0,  E_JMP,          16'd8);   // JMP
      addv(0, 15, 0, 0, 0,  E_SQ,           16'd9);   // HALT ignored in flush
      addv(0, 0,  0, 0, 0,  E_NOP,          16'd9);   // NOP
      addv(0, 9,  0, 0, 0,  E_NOP,          16'd9);   // undefined code
      addv(0, 6,  5, 0, 0,  E_LOAD,         16'd9);   // LOAD r5
      addv(0, 7,  0, 0, 5,  E_BUB,          16'd10);  // STORE src2=r5: hazard
      addv(0, 7,  0, 0, 5,  E_BUB,          16'd10);
      addv(0, 7,  0, 0, 5,  E_STORE,        16'd10);
      addv(0, 6,  7, 0, 0,  E_LOAD,         16'd11);  // LOAD r7
      addv(0, 1,  0, 1, 2,  e_alu(2'b00),   16'd12);  // independent ADD
      addv(0, 15, 0, 0, 0,  E_BUB,          16'd13);  // HALT
      addv(0, 0,  0, 0, 0,  E_BUB,          16'd13);  // drain
      addv(0, 0,  0, 0, 0,  E_BUB,          16'd13);  // drain
      addv(1, 0,  0, 0, 0,  E_HALTED,       16'd13);  // start ignored
      addv(0, 1,  0, 0, 0,  E_HALTED,       16'd13);

      reset = 1'b1; start = 1'b0; opcodeDP = 0; destAddD = 0; srcAdd1D = 0; srcAdd2D = 0;
      #2;
      reset = 1'b0;
      #1;
      check("reset ctrl", 16'(act), 16'(E_IDLE));
      check("reset count", issueCount, 16'd0);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2);
         check($sformatf("vec%0d ctrl", i), 16'(act), 16'(tbl[i].exp));
         check($sformatf("vec%0d count", i), issueCount, tbl[i].cnt);
      end

      // Asynchronous reset in the middle of a stall.
      do_reset();
      drive(1, 0, 0, 0, 0);
      drive(0, 6, 2, 0, 0);
      drive(0, 1, 0, 2, 0);
      drive(0, 1, 0, 2, 0);
      check("stall before reset", 16'(act), 16'(E_BUB));
      reset = 1'b0;
      #1;
      check("async reset ctrl", 16'(act), 16'(E_IDLE));
      check("async reset count", issueCount, 16'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0);
         check($sformatf("idle after reset %0d", i), 16'(act), 16'(E_IDLE));
      end
      drive(1, 1, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      check("run after start", 16'(act), 16'(e_alu(2'b00)));

      // Issue counter wrap.
      do_reset();
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 65535; i++) drive(0, 1, 0, 0, 0);
      drive(0, 5, 0, 0, 0);
      check("wrap ADDI ctrl", 16'(act), 16'(E_ADDI));
      check("count at 0xFFFF", issueCount, 16'hFFFF);
      drive(0, 1, 0, 0, 0);
      check("count wrapped", issueCount, 16'h0000);

      // Randomized run against the model.
      do_reset();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         int r;
         bit st;
         logic [3:0] op, d, s1, s2;
         if (m_halted && $urandom_range(0, 3) == 0) begin
            do_reset();
            model_reset();
         end
         r  = $urandom_range(0, 99);
         op = (r < 4) ? 4'd15 : (r < 12) ? 4'd8 : (r < 30) ? 4'd6 : 4'($urandom_range(0, 14));
         d  = 4'($urandom_range(0, 3));
         s1 = 4'($urandom_range(0, 3));
         s2 = 4'($urandom_range(0, 3));
         st = ($urandom_range(0, 3) == 0);
         drive(st, op, d, s1, s2);
         check($sformatf("rand%0d count", n), issueCount, m_cnt);
         model_step(st, op, d, s1, s2, exp);
         check($sformatf("rand%0d ctrl op=%0d", n, op), 16'(act), 16'(exp));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

Control unit for the 5-stage 16-bit pipelined CPU. Sits directly upstream of the datapath:
- Consumes the decode-stage opcode and source-register fields.
- Drives every per-instruction control input of the datapath (`branchC`, `flushC`, `RegWriteC`, `MemWriteC`, `MemToRegC`, `immediateC`, `forwardC`, `alufuncC`) plus the global pipeline `enable`.
- Owns run/stall/flush/halt sequencing, load-use hazard stalls and an issued-instruction counter.

## Interface
Parameters:
- `LOAD_STALL`, default 2: bubbles inserted on a load-use hazard (1..3).
- `DRAIN_CYCLES`, default 3: cycles to drain the E/M/W stages after HALT.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins execution from IDLE.
- `opcodeDP`  in  4  opcode of the instruction in decode, inst[15:12].
- `destAddD`  in  4  destination field, inst[11:8].
- `srcAdd1D`  in  4  source 1 field, inst[7:4].
- `srcAdd2D`  in  4  source 2 field, inst[3:0].
- `enable`  out  1  PC and decode-register enable.
- `branchC`  out  1  selects the branch target into the PC.
- `flushC`  out  1  inserts a bubble into the execute register.
- `RegWriteC`, `MemWriteC`, `MemToRegC`, `immediateC`, `forwardC`  out  1 each  per-instruction controls.
- `alufuncC`  out  2  ALU function: 00 add, 01 sub, 10 and, 11 or.
- `halted`  out  1  sticky; high once the HALT drain completes.
- `issueCount`  out  16  count of non-bubble instructions issued.

## Operation
Opcode map:
- 0000 NOP: all controls 0.
- 0001 ADD, 0010 SUB, 0011 AND, 0100 OR: `RegWriteC=1`, `forwardC=1`, `alufuncC` = 00/01/10/11 respectively.
- 0101 ADDI: as ADD, plus `immediateC=1`.
- 0110 LOAD: `RegWriteC=1`, `MemToRegC=1`, `immediateC=1`, `alufuncC=00`, `forwardC=0` (the result is not forwardable from E).
- 0111 STORE: `MemWriteC=1`, `immediateC=1`, `alufuncC=00`.
- 1000 JMP: `branchC=1`, all other controls 0.
- 1111 HALT: bubble; starts the drain.
- All other codes: NOP.

`forwardC` marks an instruction as a valid E-stage forwarding source.

Control outputs are Mealy: combinational from the current state and decode fields. The datapath samples them in the same cycle.

States:
- IDLE:
  - `enable=0`, all controls 0.
  - `start` moves to RUN.
- RUN:
  - `enable=1`; outputs decoded from `opcodeDP`.
  - JMP → FLUSH.
  - HALT → DRAIN, loading the counter with `DRAIN_CYCLES`.
  - Load-use hazard → STALL, loading the counter with `LOAD_STALL`. In the detecting cycle: `enable=0`, `flushC=1`, all controls 0.
  - Every non-bubble decode in RUN increments `issueCount`. The count wraps from 0xFFFF to 0x0000.
- FLUSH (one cycle):
  - `enable=1`, `flushC=1`, all other controls 0; squashes the wrongly fetched instruction.
  - No decode and no count.
  - Always returns to RUN. A JMP or HALT seen in FLUSH is ignored.
- STALL:
  - `enable=0`, `flushC=1`, all controls 0; the counter decrements each cycle.
  - When the counter reaches 1, go to RUN. The held instruction then issues normally.
- DRAIN:
  - `enable=0`, `flushC=1`, all controls 0; the counter decrements.
  - At 1, go to HALTED.
- HALTED:
  - `halted=1`, `enable=0`, all controls 0.
  - `start` is ignored; only `reset` leaves this state.

Load-use hazard rules:
- Registered `lastLoadValid` and `lastLoadDest` capture a LOAD issued in RUN. They clear on any other issued instruction or bubble.
- A hazard exists when `lastLoadValid` is set and either:
  - `srcAdd1D == lastLoadDest` and the opcode reads src1 (ALU ops, ADDI, LOAD, STORE); or
  - `srcAdd2D == lastLoadDest` and the opcode is an R-type ALU op or STORE.

Priority in RUN: hazard > HALT > JMP > normal decode.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE; `enable=0`; all controls 0; `flushC=0`.
  - `halted=0`; `issueCount=0`; `lastLoadValid=0`; counters 0.
- `start` sampled high in IDLE: `enable=1` from the next cycle.
- JMP in decode:
  - cycle N: `branchC=1`.
  - cycle N+1: `flushC=1`.
  - cycle N+2: normal decode of the branch target.
- LOAD at N followed by a dependent instruction at N+1:
  - N+1 through N+`LOAD_STALL`: `enable=0`, `flushC=1`.
  - N+`LOAD_STALL`+1: the dependent instruction issues.
- HALT at N:
  - `flushC=1` for cycles N..N+`DRAIN_CYCLES`−1.
  - `halted=1` from N+`DRAIN_CYCLES`.
- Reset asserted in any state returns to IDLE asynchronously. Stall and drain counters are discarded.

## Test plan
- Reset, pulse `start`, `opcodeDP=0001` → next cycle `enable=1`, `RegWriteC=1`, `forwardC=1`, `alufuncC=00`; `issueCount` becomes 1.
- `opcodeDP=1000` in RUN → that cycle `branchC=1`; next cycle `flushC=1`, others 0, `enable=1`. A `1111` presented during FLUSH is ignored.
- LOAD with `destAddD=3`, then ADD with `srcAdd1D=3` → 2 cycles of `enable=0`, `flushC=1`, then ADD issues. `issueCount` increases by exactly 2.
- `opcodeDP=1111` → 3 cycles of `enable=0`, `flushC=1`, then `halted=1`. A later `start` pulse does not change `halted`.
- Drop `reset` to 0 mid-STALL → all outputs at reset values within the same cycle; after release the block stays in IDLE until `start`.
- Issue 65536 ADDs → `issueCount` wraps from 0xFFFF to 0x0000; `opcodeDP=0101` yields `immediateC=1`, `alufuncC=00`.
